// File: rtl/circular_fifo.sv
// Show-ahead FIFO whose depth (max+1) can be chosen at run time, up to 2^ADDR_WIDTH words.
// Both pointers wrap at the latched limit. The limit is only reloaded while the FIFO sits empty.
module circular_fifo #(
    parameter int WIDTH      = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] max,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  full,
    output logic                  empty
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [WIDTH-1:0]      r_mem [DEPTH];
    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [ADDR_WIDTH-1:0] r_max_q;
    logic [ADDR_WIDTH:0]   r_count;

    logic [ADDR_WIDTH:0]   w_depth;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_wr;
    logic                  w_rd;

    function automatic logic [ADDR_WIDTH-1:0] f_next(input logic [ADDR_WIDTH-1:0] p,
                                                     input logic [ADDR_WIDTH-1:0] lim);
        return (p == lim) ? '0 : p + 1'b1;
    endfunction

    assign w_depth = {1'b0, r_max_q} + {{ADDR_WIDTH{1'b0}}, 1'b1};
    assign w_full  = (r_count == w_depth);
    assign w_empty = (r_count == '0);
    // Handshakes depend only on registered state, so no ready/valid comb paths cross the FIFO.
    assign w_wr    = in_valid && !w_full;
    assign w_rd    = out_ready && !w_empty;

    assign in_ready  = !w_full;
    assign out_valid = !w_empty;
    assign full      = w_full;
    assign empty     = w_empty;
    assign count     = r_count;
    assign out_data  = r_mem[r_rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_max_q  <= max;
        end else if (w_empty && !w_wr) begin
            // Idle and empty: safe point to pick up a new depth and re-home the pointers.
            r_max_q  <= max;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= f_next(r_wr_ptr, r_max_q);
            if (w_rd) r_rd_ptr <= f_next(r_rd_ptr, r_max_q);
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr_ptr] <= in_data;
    end
endmodule

// File: tb/tb_circular_fifo.sv
// Directed bench for circular_fifo: a queue scoreboard tracks accepted words, count and latched depth.
module tb_circular_fifo;
    localparam int W  = 8;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [AW-1:0] max = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  out_data;
    logic [AW:0]   count;
    logic          full;
    logic          empty;

    int errors = 0;
    int checks = 0;
    logic [W-1:0] sb[$];
    int m_count = 0;
    int m_max   = 0;

    circular_fifo #(.WIDTH(W), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst_n(rst_n), .max(max),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .count(count), .full(full), .empty(empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive after a falling edge, check handshake/head, then check state after the edge.
    task automatic cyc(input logic v, input logic [W-1:0] d, input logic r);
        logic aw, ar, efull;
        logic [W-1:0] tmp;
        in_valid = v; in_data = d; out_ready = r;
        #1;
        efull = (m_count == m_max + 1);
        aw = v && !efull;
        ar = r && (m_count != 0);
        chk("in_ready", in_ready, !efull);
        chk("out_valid", out_valid, m_count != 0);
        if (m_count != 0) chk("out_data", out_data, sb[0]);
        @(posedge clk);
        if (m_count == 0 && !aw) m_max = max;
        if (aw) sb.push_back(d);
        if (ar) tmp = sb.pop_front();
        m_count = sb.size();
        @(negedge clk);
        chk("count", count, m_count);
        chk("full", full, m_count == m_max + 1);
        chk("empty", empty, m_count == 0);
    endtask

    initial begin
        // Reset with max=3
        max = 4'd3;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        m_max = 3;
        @(negedge clk) rst_n = 1'b1;

        // Basic write of A..D, refused 5th, drain
        cyc(1, 8'hA1, 0); cyc(1, 8'hB2, 0); cyc(1, 8'hC3, 0); cyc(1, 8'hD4, 0);
        chk("fill4_count", count, 4);
        chk("fill4_full", full, 1);
        cyc(1, 8'hE5, 0);
        chk("refused_count", count, 4);
        for (int i = 0; i < 4; i++) cyc(0, 0, 1);
        chk("drained_empty", empty, 1);

        // Pointer wrap with max=2, one word in flight
        max = 4'd2;
        cyc(0, 0, 0);
        for (int i = 0; i < 10; i++) cyc(1, 8'(8'h30 + i), 1);
        cyc(0, 0, 1);
        chk("wrap_sb_empty", sb.size(), 0);

        // Simultaneous read+write at count=2
        cyc(1, 8'h51, 0); cyc(1, 8'h52, 0);
        cyc(1, 8'h53, 1); cyc(1, 8'h54, 1);
        chk("rw2_count", count, 2);

        // Simultaneous read+write at full (max=2 -> depth 3)
        cyc(1, 8'h55, 0);
        chk("full3", full, 1);
        cyc(1, 8'h56, 1);
        chk("rwfull_count", count, 2);
        for (int i = 0; i < 2; i++) cyc(0, 0, 1);

        // Depth change only takes effect after an empty idle edge
        max = 4'd7;
        cyc(0, 0, 0);
        cyc(1, 8'h61, 0); cyc(1, 8'h62, 0);
        max = 4'd1;
        cyc(1, 8'h63, 0); cyc(1, 8'h64, 0);
        chk("old_depth_full", full, 0);
        chk("old_depth_count", count, 4);
        for (int i = 0; i < 4; i++) cyc(0, 0, 1);
        cyc(0, 0, 0);
        cyc(1, 8'h71, 0); cyc(1, 8'h72, 0);
        chk("new_depth_full", full, 1);
        cyc(1, 8'h73, 0);
        chk("new_depth_count", count, 2);
        for (int i = 0; i < 2; i++) cyc(0, 0, 1);

        // Asynchronous reset mid-stream at count=3
        max = 4'd5;
        cyc(0, 0, 0);
        cyc(1, 8'h81, 0); cyc(1, 8'h82, 0); cyc(1, 8'h83, 0);
        chk("pre_rst_count", count, 3);
        in_valid = 1'b0; out_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("async_count", count, 0);
        chk("async_empty", empty, 1);
        chk("async_out_valid", out_valid, 0);
        #1 rst_n = 1'b1;
        sb.delete();
        m_count = 0;
        m_max = 5;
        @(negedge clk);
        cyc(1, 8'h91, 0);
        cyc(0, 0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/circular_fifo.md
# circular_fifo

Synchronous FIFO with a run-time programmable depth. Read and write pointers advance with the same wrap-at-`max` rule as our circular counter. It buffers a valid/ready data stream between a producer and a consumer in the control path, so a depth smaller than the physical storage can be selected without re-synthesis. Storage is a register array with a show-ahead read port, so the head entry is always presented on `out_data`.

## Interface
- `WIDTH`, default 8: data word width in bits.
- `ADDR_WIDTH`, default 4: pointer width. Physical storage is 2^ADDR_WIDTH entries.

- `clk`  in  1: single clock. All state updates on the rising edge.
- `rst_n`  in  1: reset, asynchronous and active-low.
- `max`  in  ADDR_WIDTH: last usable index. Effective depth is `max`+1. Unsigned.
- `in_valid`  in  1: producer presents `in_data`.
- `in_ready`  out  1: FIFO can accept a word. Equals !`full`.
- `in_data`  in  WIDTH: write data.
- `out_valid`  out  1: head word available. Equals !`empty`.
- `out_ready`  in  1: consumer takes the head word.
- `out_data`  out  WIDTH: head word, read combinationally from storage at the read pointer.
- `count`  out  ADDR_WIDTH+1: number of stored words.
- `full`  out  1: `count` == `max_q`+1.
- `empty`  out  1: `count` == 0.

## Operation
- Internal state: `wr_ptr`, `rd_ptr` (ADDR_WIDTH each), `count`, `max_q` (latched depth limit), and the storage array.
- A write is accepted when `in_valid` && `in_ready` is true at a rising edge.
  - `mem[wr_ptr]` <= `in_data`.
  - `wr_ptr` advances.
- A read is accepted when `out_valid` && `out_ready` is true at a rising edge.
  - `rd_ptr` advances.
- Pointer advance is circular. If `ptr` == `max_q`, the next value is 0; otherwise it is `ptr`+1. Arithmetic is unsigned with no carry out.
- Count update:
  - Increments on write-only.
  - Decrements on read-only.
  - Unchanged on simultaneous read and write, or when idle.
- Depth latch:
  - Applies on any edge where `count` == 0 and no write is accepted.
  - At such an edge: `max_q` <= `max`, `wr_ptr` <= 0, `rd_ptr` <= 0.
  - Changes to `max` while the FIFO is non-empty have no effect until the FIFO next sits empty for an edge without a write.
- Full: no write is accepted, even if a read happens in the same cycle. There is no write-through-when-full.
- Empty: no read is accepted. There is no bypass; `in_data` never appears on `out_data` in the same cycle.
- `max` = 0 gives a depth-1 FIFO, with `full` set after a single write.
- `max` = 2^ADDR_WIDTH-1 uses the entire array.
- Storage contents are not reset. `out_data` is don't-care while `empty`.

## Timing
- Reset (`rst_n` low, asynchronous): `wr_ptr`=0, `rd_ptr`=0, `count`=0, `max_q`=`max`.
  - Hence `empty`=1, `full`=0, `in_ready`=1, `out_valid`=0.
- After `rst_n` deasserts, operation starts at the first rising edge.
- Reset asserted mid-operation clears all pointers and `count` immediately. All buffered words are lost.
- Write-to-read latency is 1 cycle: a word written at edge N gives `out_valid`=1 and `out_data`=word after edge N.
- `in_ready` is a function of registered state only. It never depends combinationally on `out_ready`.
- `out_valid` is a function of registered state only. It never depends combinationally on `in_valid`.
- Sustained throughput is 1 word per cycle when neither `full` nor `empty`.
- `full` and `empty` update on the same edge as `count`.

## Test plan
- **Reset and basic write:** reset with `max`=3, then write A,B,C,D on consecutive cycles with `out_ready`=0.
  - Expect `count` 1..4 and `full`=1 after the 4th write.
  - A 5th `in_valid` is not accepted; `count` stays 4.
  - Set `out_ready`=1: expect A,B,C,D in order, then `empty`=1.
- **Pointer wrap:** with `max`=2, stream 10 words while holding `out_ready`=1 (1 in flight).
  - Expect all 10 words out in order with no loss.
  - `wr_ptr` sequence 0,1,2,0,1,…
- **Simultaneous read and write at `count`=2:** expect `count` to stay 2, and order to be preserved.
- **Simultaneous read and write at full:** expect the read to be accepted and the write to be refused (`in_ready`=0). `count` goes from `max`+1 to `max`.
- **Depth change:** fill 2 words with `max`=7, then set `max`=1.
  - Expect no change in `full` behaviour until the FIFO drains.
  - After the FIFO has been empty for 1 idle edge, 2 writes give `full`=1.
- **Asynchronous reset mid-stream:** pulse `rst_n` low between edges while `count`=3.
  - Expect `count`=0 and `empty`=1 immediately, without waiting for a clock edge.
